// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared constants for the iterative multiply/divide unit: default widths,
// iteration count, funct codes for the HI/LO instructions, and the FSM state
// encoding. Imported by muldiv_unit.
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

   localparam int DEF_WORD_WIDTH     = 32;
   localparam int DEF_ALUFUNCT_WIDTH = 6;
   localparam int DEF_MD_ITER        = DEF_WORD_WIDTH;

   localparam logic [DEF_ALUFUNCT_WIDTH-1:0] ALUFUNCT_MTHI  = 6'h11;
   localparam logic [DEF_ALUFUNCT_WIDTH-1:0] ALUFUNCT_MTLO  = 6'h13;
   localparam logic [DEF_ALUFUNCT_WIDTH-1:0] ALUFUNCT_MULT  = 6'h18;
   localparam logic [DEF_ALUFUNCT_WIDTH-1:0] ALUFUNCT_MULTU = 6'h19;
   localparam logic [DEF_ALUFUNCT_WIDTH-1:0] ALUFUNCT_DIV   = 6'h1A;
   localparam logic [DEF_ALUFUNCT_WIDTH-1:0] ALUFUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// One radix-2 step per cycle over a shared (2*WORD_WIDTH+1)-bit accumulator:
// shift-add for multiply, restoring subtraction for divide. Signed ops run on
// magnitudes and the signs are applied in a final FIX cycle. MTHI/MTLO write
// HI/LO directly when the unit is idle.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   md_start     request valid (ID/EX holds a mult/div/MT op)
//   md_function  funct code of the request
//   md_src1      rs operand: multiplicand / dividend / MTHI-MTLO data
//   md_src2      rt operand: multiplier / divisor
//   md_flush     pipeline flush, aborts any in-flight op
//   md_busy      op in flight
//   md_stall     request arrives while busy; hazard unit holds ID/EX
//   md_done      one-cycle pulse after HI/LO are written by mult/div
//   hi_out       HI register
//   lo_out       LO register
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
   parameter int ALUFUNCT_WIDTH = DEF_ALUFUNCT_WIDTH,
   parameter int MD_ITER        = WORD_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      md_start,
   input  logic [ALUFUNCT_WIDTH-1:0] md_function,
   input  logic [WORD_WIDTH-1:0]     md_src1,
   input  logic [WORD_WIDTH-1:0]     md_src2,
   input  logic                      md_flush,
   output logic                      md_busy,
   output logic                      md_stall,
   output logic                      md_done,
   output logic [WORD_WIDTH-1:0]     hi_out,
   output logic [WORD_WIDTH-1:0]     lo_out
);

   localparam int W     = WORD_WIDTH;
   localparam int ACC_W = 2 * W + 1;
   localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

   md_state_t            state_reg, state_next;
   logic [CNT_W-1:0]     count_reg, count_next;
   logic [ACC_W-1:0]     acc_reg, acc_next;
   logic [W-1:0]         opnd_reg, opnd_next;      // |multiplicand| or |divisor|
   logic [W-1:0]         src1_reg, src1_next;      // raw dividend for divide-by-zero
   logic                 is_div_reg, is_div_next;
   logic                 neg_res_reg, neg_res_next; // operand signs differ (signed op)
   logic                 neg_rem_reg, neg_rem_next; // dividend negative (signed div)
   logic                 div_zero_reg, div_zero_next;
   logic [W-1:0]         hi_reg, hi_next;
   logic [W-1:0]         lo_reg, lo_next;
   logic                 done_reg, done_next;

   // Iteration datapath
   logic [W:0]           mul_sum;
   logic [ACC_W-1:0]     mul_step;
   logic [W:0]           rem_shift;
   logic [W+1:0]         div_diff;
   logic [ACC_W-1:0]     div_step;

   // Final sign fix-up
   logic [2*W-1:0]       prod_fixed;
   logic [W-1:0]         quot_fixed;
   logic [W-1:0]         rem_fixed;

   // Issue decode
   logic                 op_is_md;
   logic                 op_signed;
   logic                 a_neg;
   logic                 b_neg;

   always_comb begin
      // Multiply: low half holds the remaining multiplier bits; each step adds
      // the multiplicand into the upper half when the current LSB is set and
      // shifts the whole accumulator right. The top bit catches the carry.
      mul_sum  = acc_reg[ACC_W-1:W] + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
      mul_step = {1'b0, mul_sum, acc_reg[W-1:1]};

      // Restoring divide: shift the remainder left pulling in the next dividend
      // bit, trial-subtract the divisor, keep the result if it did not borrow.
      rem_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
      div_diff  = {1'b0, rem_shift} - {2'b00, opnd_reg};
      if (div_diff[W+1]) begin
         div_step = {rem_shift, acc_reg[W-2:0], 1'b0};
      end else begin
         div_step = {div_diff[W:0], acc_reg[W-2:0], 1'b1};
      end

      prod_fixed = neg_res_reg ? -acc_reg[2*W-1:0] : acc_reg[2*W-1:0];
      quot_fixed = neg_res_reg ? -acc_reg[W-1:0]   : acc_reg[W-1:0];
      rem_fixed  = neg_rem_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
   end

   always_comb begin
      op_is_md  = (md_function == ALUFUNCT_MULT) || (md_function == ALUFUNCT_MULTU) ||
                  (md_function == ALUFUNCT_DIV)  || (md_function == ALUFUNCT_DIVU);
      op_signed = (md_function == ALUFUNCT_MULT) || (md_function == ALUFUNCT_DIV);
      a_neg     = op_signed && md_src1[W-1];
      b_neg     = op_signed && md_src2[W-1];
   end

   // FSM next-state and datapath next values
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      acc_next      = acc_reg;
      opnd_next     = opnd_reg;
      src1_next     = src1_reg;
      is_div_next   = is_div_reg;
      neg_res_next  = neg_res_reg;
      neg_rem_next  = neg_rem_reg;
      div_zero_next = div_zero_reg;
      hi_next       = hi_reg;
      lo_next       = lo_reg;
      done_next     = 1'b0;

      unique case (state_reg)
         MD_IDLE: begin
            if (md_start) begin
               if (op_is_md) begin
                  acc_next      = {{(W+1){1'b0}}, (a_neg ? -md_src1 : md_src1)};
                  opnd_next     = b_neg ? -md_src2 : md_src2;
                  src1_next     = md_src1;
                  is_div_next   = (md_function == ALUFUNCT_DIV) || (md_function == ALUFUNCT_DIVU);
                  neg_res_next  = a_neg ^ b_neg;
                  neg_rem_next  = a_neg;
                  div_zero_next = (md_src2 == '0);
                  count_next    = '0;
                  state_next    = MD_CALC;
               end else if (md_function == ALUFUNCT_MTHI) begin
                  hi_next = md_src1;
               end else if (md_function == ALUFUNCT_MTLO) begin
                  lo_next = md_src1;
               end
            end
         end

         MD_CALC: begin
            acc_next   = is_div_reg ? div_step : mul_step;
            count_next = count_reg + CNT_W'(1);
            if (count_reg == CNT_W'(MD_ITER - 1)) begin
               state_next = MD_FIX;
            end
         end

         MD_FIX: begin
            if (!is_div_reg) begin
               hi_next = prod_fixed[2*W-1:W];
               lo_next = prod_fixed[W-1:0];
            end else if (div_zero_reg) begin
               // Divide by zero reports the dividend exactly as issued.
               hi_next = src1_reg;
               lo_next = '1;
            end else begin
               hi_next = rem_fixed;
               lo_next = quot_fixed;
            end
            done_next  = 1'b1;
            state_next = MD_IDLE;
         end

         default: begin
            state_next = MD_IDLE;
         end
      endcase

      // Flush dominates everything, including a same-cycle start or MT write.
      if (md_flush) begin
         state_next = MD_IDLE;
         hi_next    = hi_reg;
         lo_next    = lo_reg;
         done_next  = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= MD_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath and architectural registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg    <= '0;
         acc_reg      <= '0;
         opnd_reg     <= '0;
         src1_reg     <= '0;
         is_div_reg   <= 1'b0;
         neg_res_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         div_zero_reg <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         done_reg     <= 1'b0;
      end else begin
         count_reg    <= count_next;
         acc_reg      <= acc_next;
         opnd_reg     <= opnd_next;
         src1_reg     <= src1_next;
         is_div_reg   <= is_div_next;
         neg_res_reg  <= neg_res_next;
         neg_rem_reg  <= neg_rem_next;
         div_zero_reg <= div_zero_next;
         hi_reg       <= hi_next;
         lo_reg       <= lo_next;
         done_reg     <= done_next;
      end
   end

   assign md_busy  = (state_reg != MD_IDLE);
   assign md_stall = md_start & md_busy;
   assign md_done  = done_reg;
   assign hi_out   = hi_reg;
   assign lo_out   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit. A behavioural model (plain 64-bit arithmetic
// plus a countdown of the fixed latency) predicts HI/LO/busy/done/stall and is
// compared on every falling edge; literal checks pin the model on known cases.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic        clk;
   logic        rst_n;
   logic        md_start;
   logic [5:0]  md_function;
   logic [31:0] md_src1;
   logic [31:0] md_src2;
   logic        md_flush;
   logic        md_busy;
   logic        md_stall;
   logic        md_done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int tests = 0;
   int fails = 0;

   muldiv_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .md_start    (md_start),
      .md_function (md_function),
      .md_src1     (md_src1),
      .md_src2     (md_src2),
      .md_flush    (md_flush),
      .md_busy     (md_busy),
      .md_stall    (md_stall),
      .md_done     (md_done),
      .hi_out      (hi_out),
      .lo_out      (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [63:0] model_result(input logic [5:0] f,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
      longint sa, sb, q, r, p;
      logic [63:0] res;
      sa  = $signed(a);
      sb  = $signed(b);
      res = '0;
      case (f)
         F_MULTU: res = {32'b0, a} * {32'b0, b};
         F_MULT: begin
            p   = sa * sb;
            res = p;
         end
         F_DIVU: res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
         F_DIV: begin
            if (b == 0) begin
               res = {a, 32'hFFFFFFFF};
            end else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   logic [31:0] m_hi, m_lo, r_hi, r_lo;
   int          m_rem;
   logic        m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_rem  <= 0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (md_flush) begin
            m_rem <= 0;
         end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_hi   <= r_hi;
               m_lo   <= r_lo;
               m_done <= 1'b1;
            end
         end else if (md_start) begin
            case (md_function)
               F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  {r_hi, r_lo} <= model_result(md_function, md_src1, md_src2);
                  m_rem        <= 33;
               end
               F_MTHI:  m_hi <= md_src1;
               F_MTLO:  m_lo <= md_src1;
               default: ;
            endcase
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      chk1("md_busy", md_busy, m_rem != 0);
      chk1("md_done", md_done, m_done);
      chk1("md_stall", md_stall, md_start && (m_rem != 0));
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int done_at, output int busy_cnt);
      int n;
      md_function = f;
      md_src1     = a;
      md_src2     = b;
      md_start    = 1'b1;
      step();
      md_start = 1'b0;
      n        = 1;
      busy_cnt = 0;
      while (!md_done && n < 40) begin
         if (md_busy) busy_cnt++;
         step();
         n++;
      end
      done_at = n;
      if (!md_done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: no md_done within %0d cycles", n);
      end
   endtask

   task automatic op_result(input string name, input logic [5:0] f,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int d, bc;
      run_op(f, a, b, d, bc);
      chk({name, "_hi"}, hi_out, exp_hi);
      chk({name, "_lo"}, lo_out, exp_lo);
      $display("[TB] %s a=%08h b=%08h -> hi=%08h lo=%08h", name, a, b, hi_out, lo_out);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          done_at, busy_cnt, guard;
      logic [31:0] hi_before, lo_before;

      rst_n       = 1'b0;
      md_start    = 1'b0;
      md_function = '0;
      md_src1     = '0;
      md_src2     = '0;
      md_flush    = 1'b0;
      repeat (3) step();
      chk("reset_hi", hi_out, 32'h0);
      chk("reset_lo", lo_out, 32'h0);
      chk1("reset_busy", md_busy, 1'b0);
      chk1("reset_done", md_done, 1'b0);
      rst_n = 1'b1;
      step();

      // MULTU max x max with latency check
      run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, done_at, busy_cnt);
      chk("multu_max_hi", hi_out, 32'hFFFFFFFE);
      chk("multu_max_lo", lo_out, 32'h00000001);
      chk("multu_done_at", 32'(done_at), 32'd34);
      chk("multu_busy_cycles", 32'(busy_cnt), 32'd33);
      $display("[TB] MULTU max done_at=%0d busy=%0d hi=%08h lo=%08h", done_at, busy_cnt, hi_out, lo_out);

      op_result("mult_neg3x7", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      op_result("div_neg7by2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      op_result("div_7byneg2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      op_result("divu_7by0", F_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
      op_result("div_neg7by0", F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
      op_result("div_minbyneg1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      op_result("multu_2p16sq", F_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
      op_result("divu_100by7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      // MTLO while idle
      hi_before   = hi_out;
      md_function = F_MTLO;
      md_src1     = 32'h12345678;
      md_start    = 1'b1;
      step();
      md_start = 1'b0;
      chk("mtlo_lo", lo_out, 32'h12345678);
      chk("mtlo_hi_kept", hi_out, hi_before);
      chk1("mtlo_no_done", md_done, 1'b0);
      chk1("mtlo_no_busy", md_busy, 1'b0);
      $display("[TB] MTLO -> lo=%08h", lo_out);

      // MTHI held while a MULT is in flight
      md_function = F_MULT;
      md_src1     = 32'd2;
      md_src2     = 32'd3;
      md_start    = 1'b1;
      step();
      hi_before   = hi_out;
      md_function = F_MTHI;
      md_src1     = 32'hCAFEF00D;
      step();
      chk1("mthi_stall", md_stall, 1'b1);
      chk("mthi_hi_held", hi_out, hi_before);
      guard = 0;
      while (md_busy && guard < 40) begin
         step();
         guard++;
      end
      chk1("mthi_wait_bounded", md_busy, 1'b0);
      chk1("mult_done_pulse", md_done, 1'b1);
      chk("mult_2x3_lo", lo_out, 32'd6);
      chk("mult_2x3_hi", hi_out, 32'd0);
      step();
      md_start = 1'b0;
      chk("mthi_applied", hi_out, 32'hCAFEF00D);
      chk("mthi_lo_kept", lo_out, 32'd6);
      $display("[TB] MTHI after MULT -> hi=%08h lo=%08h", hi_out, lo_out);

      // Flush mid DIVU
      hi_before   = hi_out;
      lo_before   = lo_out;
      md_function = F_DIVU;
      md_src1     = 32'd1000;
      md_src2     = 32'd9;
      md_start    = 1'b1;
      step();
      md_start = 1'b0;
      repeat (9) step();
      md_flush = 1'b1;
      step();
      md_flush = 1'b0;
      chk1("flush_busy", md_busy, 1'b0);
      chk("flush_hi", hi_out, hi_before);
      chk("flush_lo", lo_out, lo_before);
      repeat (40) step();
      chk("flush_hi_late", hi_out, hi_before);
      $display("[TB] flush DIVU -> busy=%0b hi=%08h lo=%08h", md_busy, hi_out, lo_out);

      // Flush together with start
      md_function = F_MULT;
      md_src1     = 32'd3;
      md_src2     = 32'd5;
      md_start    = 1'b1;
      md_flush    = 1'b1;
      step();
      md_start = 1'b0;
      md_flush = 1'b0;
      chk1("flush_start_busy", md_busy, 1'b0);
      repeat (40) step();
      chk("flush_start_lo", lo_out, lo_before);
      $display("[TB] flush+start -> busy=%0b lo=%08h", md_busy, lo_out);

      // Unknown funct
      md_function = 6'h20;
      md_start    = 1'b1;
      step();
      md_start = 1'b0;
      chk1("unknown_busy", md_busy, 1'b0);
      $display("[TB] unknown funct -> busy=%0b", md_busy);

      // Asynchronous reset mid-MULT
      md_function = F_MULT;
      md_src1     = 32'h00001234;
      md_src2     = 32'h00005678;
      md_start    = 1'b1;
      step();
      md_start = 1'b0;
      repeat (5) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_hi", hi_out, 32'h0);
      chk("async_rst_lo", lo_out, 32'h0);
      chk1("async_rst_busy", md_busy, 1'b0);
      $display("[TB] async reset -> hi=%08h lo=%08h busy=%0b", hi_out, lo_out, md_busy);
      step();
      rst_n = 1'b1;
      step();
      op_result("multu_3x5", F_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU. It takes the same operands and funct code from the ID/EX register and executes MULT/MULTU/DIV/DIVU over multiple cycles. Results go into architectural HI/LO registers, which MEM/WB read for MFHI/MFLO. It also performs MTHI/MTLO writes and drives a stall to the hazard unit while busy.

Parameters:
WORD_WIDTH, 32, operand and HI/LO width (from defines.v)
ALUFUNCT_WIDTH, 6, funct field width (from defines.v)
MD_ITER, 32, iterations per mult/div (equals WORD_WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
md_start  in  1  request valid this cycle (ID/EX holds an md op)
md_function  in  ALUFUNCT_WIDTH  funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13
md_src1  in  WORD_WIDTH  rs operand (multiplicand / dividend / MT data)
md_src2  in  WORD_WIDTH  rt operand (multiplier / divisor)
md_flush  in  1  pipeline flush; aborts in-flight op
md_busy  out  1  op in flight
md_stall  out  1  md_start & md_busy; hazard unit holds ID/EX
md_done  out  1  one-cycle pulse when HI/LO updated by mult/div
hi_out  out  WORD_WIDTH  HI register
lo_out  out  WORD_WIDTH  LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). Reset forces state=IDLE, HI=LO=0, md_busy=0, md_done=0, counter=0. Reset takes effect immediately, including mid-operation.
- FSM states: IDLE, CALC, FIX.
  - IDLE: md_start with a mult/div funct and no flush → load |src1| and |src2| (signed ops) or raw operands (unsigned), latch sign flags, clear the accumulator, counter=0 → CALC.
  - CALC: one radix-2 step per cycle (shift-add multiply; restoring divide). After the step with counter=MD_ITER-1 → FIX.
  - FIX: apply signs and write HI/LO. State → IDLE; md_done=1 for the following cycle.
- Latency: start sampled on edge k; HI/LO written on edge k+33; md_done high in the cycle after edge k+33. md_busy = (state!=IDLE), high for 33 cycles.
- Mult results: HI:LO = 64-bit product. For MULT, the product is negated if the operand signs differ.
- Div results: LO = quotient, HI = remainder. For DIV, the quotient is negated if the signs differ, and the remainder takes the dividend's sign.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap; no trap).
- Divide by zero (DIV or DIVU): HI=src1 as issued, LO=0xFFFFFFFF, same latency, no error.
- MTHI/MTLO: accepted only in IDLE. Writes HI/LO at the next edge, no busy, no md_done.
- md_start while busy: ignored; md_stall=1. Upstream holds the request until md_busy falls. A new start is accepted in the cycle md_done is high, since state is IDLE.
- Unknown funct with md_start: ignored, no state change.
- md_flush: any state → IDLE at the next edge. HI/LO keep their prior values; no md_done. Flush together with start in IDLE: flush wins and the start is dropped.
- HI/LO change only at FIX, MTHI/MTLO, or reset.

Decomposition:
- defines.v: add ALUFUNCT_MTHI, ALUFUNCT_MTLO, MD_ITER, and the state encodings MD_IDLE, MD_CALC, MD_FIX. MULT/MULTU/DIV/DIVU codes already exist there.
- One module. The FSM, counter, and iterative datapath share a 65-bit accumulator register, so no sub-module is needed.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; md_done exactly 34 cycles after the start cycle; md_busy high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 → HI=0x00000007, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTLO 0x12345678 while idle → lo_out=0x12345678 next cycle, no md_done. MTHI issued during a MULT → md_stall=1 and HI unchanged until the MULT completes; the held MTHI then applies.
- Start DIVU, assert md_flush at cycle 10 → md_busy=0 next cycle, HI/LO keep their pre-op values, no md_done. Flush and start in the same cycle → request dropped.
- Assert rst_n low mid-MULT, asynchronously between edges → hi_out=lo_out=0 and md_busy=0 immediately. After release, a new MULTU 3×5 → LO=15, HI=0.
